// File: rtl/dcache_tl_e_grantack_sched.sv
// rtl/dcache_tl_e_grantack_sched.sv - TileLink E-channel GrantAck scheduler for the hart 0 data cache
// Queues sink IDs from last Grant/GrantData beats and replays them on E in arrival order.
module dcache_tl_e_grantack_sched #(
  parameter int SINK_W  = 1,
  parameter int DEPTH   = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     d_valid,
  input  logic                     d_ready,
  input  logic [2:0]               d_opcode,
  input  logic [SINK_W-1:0]        d_sink,
  input  logic                     d_last,
  output logic                     d_block,
  output logic                     e_valid,
  input  logic                     e_ready,
  output logic [SINK_W-1:0]        e_sink,
  output logic [$clog2(DEPTH):0]   pending_count,
  output logic                     idle,
  output logic                     timeout_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [SINK_W-1:0] mem_q [DEPTH];
  logic [SINK_W-1:0] mem_d [DEPTH];
  logic [PW-1:0]     wrptr_q, wrptr_d, rdptr_q, rdptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              err_q, err_d;

  logic push, pop, full, wr_en;

  assign full  = (count_q == CW'(DEPTH));
  assign push  = d_valid & d_ready & d_last & ((d_opcode == 3'd4) | (d_opcode == 3'd5));
  assign pop   = e_valid & e_ready;
  // A full queue can still take a push when the head leaves in the same cycle.
  assign wr_en = push & (~full | pop);

  assign e_valid       = (count_q != '0);
  assign e_sink        = mem_q[rdptr_q];
  assign d_block       = full;
  assign pending_count = count_q;
  assign idle          = (count_q == '0);
  assign timeout_err   = err_q;

  always_comb begin
    mem_d   = mem_q;
    wrptr_d = wrptr_q;
    rdptr_d = rdptr_q;
    count_d = count_q;
    if (wr_en) begin
      mem_d[wrptr_q] = d_sink;
      wrptr_d        = wrptr_q + PW'(1);
    end
    if (pop) begin
      rdptr_d = rdptr_q + PW'(1);
    end
    if (wr_en && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!wr_en && pop) begin
      count_d = count_q - CW'(1);
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    if (!e_valid || pop) begin
      tmo_d = '0;
    end else if (tmo_q != TW'(TIMEOUT)) begin
      tmo_d = tmo_q + TW'(1);
    end
    err_d = err_q | (tmo_d == TW'(TIMEOUT));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrptr_q <= '0;
      rdptr_q <= '0;
      count_q <= '0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      mem_q   <= mem_d;
      wrptr_q <= wrptr_d;
      rdptr_q <= rdptr_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
    end
  end

  // Upstream ignored d_block: the GrantAck for this beat is lost.
  a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
    !(push && full && !pop));

endmodule

// File: tb/tb_dcache_tl_e_grantack_sched.sv
// tb/tb_dcache_tl_e_grantack_sched.sv - scoreboard bench for dcache_tl_e_grantack_sched
// Expected sinks are queued as pushes are seen and compared as E beats fire.
module tb_dcache_tl_e_grantack_sched;

  localparam int SINK_W  = 2;
  localparam int DEPTH   = 2;
  localparam int TIMEOUT = 8;

  logic              clock = 1'b0;
  logic              reset;
  logic              d_valid, d_ready, d_last;
  logic [2:0]        d_opcode;
  logic [SINK_W-1:0] d_sink;
  logic              d_block, e_valid, e_ready;
  logic [SINK_W-1:0] e_sink;
  logic [$clog2(DEPTH):0] pending_count;
  logic              idle, timeout_err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [SINK_W-1:0] exp_q [$];
  int                stall_cnt = 0;
  logic              err_exp   = 1'b0;

  always #5 clock = ~clock;

  dcache_tl_e_grantack_sched #(
    .SINK_W (SINK_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .d_valid      (d_valid),
    .d_ready      (d_ready),
    .d_opcode     (d_opcode),
    .d_sink       (d_sink),
    .d_last       (d_last),
    .d_block      (d_block),
    .e_valid      (e_valid),
    .e_ready      (e_ready),
    .e_sink       (e_sink),
    .pending_count(pending_count),
    .idle         (idle),
    .timeout_err  (timeout_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // Scoreboard: sample mid-cycle, then account for what the coming edge will do.
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      stall_cnt = 0;
      err_exp   = 1'b0;
    end else begin
      automatic bit pop_f  = e_valid && e_ready;
      automatic bit push_f = d_valid && d_ready && d_last && (d_opcode == 3'd4 || d_opcode == 3'd5);
      chk("pending", 32'(pending_count), 32'(exp_q.size()));
      chk("e_valid", 32'(e_valid), 32'(exp_q.size() != 0));
      chk("idle", 32'(idle), 32'(exp_q.size() == 0));
      chk("d_block", 32'(d_block), 32'(exp_q.size() == DEPTH));
      chk("timeout_err", 32'(timeout_err), 32'(err_exp));
      if (pop_f) begin
        if (exp_q.size() == 0) chk("pop_unexpected", 32'(e_sink), 32'hffff_ffff);
        else chk("e_sink_order", 32'(e_sink), 32'(exp_q.pop_front()));
      end
      if (push_f && (exp_q.size() < DEPTH)) exp_q.push_back(d_sink);
      if (e_valid && !e_ready) begin
        stall_cnt++;
        if (stall_cnt >= TIMEOUT) err_exp = 1'b1;
      end else begin
        stall_cnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic beat(input logic [2:0] op, input logic [SINK_W-1:0] sink, input logic last);
    d_valid  = 1'b1;
    d_ready  = 1'b1;
    d_opcode = op;
    d_sink   = sink;
    d_last   = last;
    tick(1);
    d_valid  = 1'b0;
    d_last   = 1'b0;
  endtask

  initial begin
    reset = 1'b1; d_valid = 1'b0; d_ready = 1'b0; d_opcode = 3'd0;
    d_sink = '0; d_last = 1'b0; e_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    chk("rst_e_sink", 32'(e_sink), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_err", 32'(timeout_err), 32'd0);

    // single Grant: visible the next cycle, popped one cycle later
    tick(1);
    beat(3'd4, 2'd1, 1'b1);
    chk("t1_e_valid", 32'(e_valid), 32'd1);
    chk("t1_e_sink", 32'(e_sink), 32'd1);
    e_ready = 1'b1;
    tick(1);
    e_ready = 1'b0;
    chk("t1_idle", 32'(idle), 32'd1);

    // multi-beat GrantData pushes once; AccessAck never pushes
    for (int i = 0; i < 4; i++) begin
      beat(3'd5, 2'd0, i == 3);
      chk("t2_pending", 32'(pending_count), 32'(i == 3));
    end
    beat(3'd1, 2'd2, 1'b1);
    chk("t2_accessack", 32'(pending_count), 32'd1);
    e_ready = 1'b1;
    tick(2);
    e_ready = 1'b0;

    // fill to DEPTH, then drain in order
    beat(3'd4, 2'd0, 1'b1);
    beat(3'd4, 2'd1, 1'b1);
    chk("t3_block", 32'(d_block), 32'd1);
    chk("t3_pending", 32'(pending_count), 32'd2);
    e_ready = 1'b1;
    tick(1);
    chk("t3_unblock", 32'(d_block), 32'd0);
    tick(2);
    e_ready = 1'b0;

    // push and pop together while full, across pointer wrap
    beat(3'd4, 2'd2, 1'b1);
    beat(3'd5, 2'd3, 1'b1);
    e_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      beat(3'd4, SINK_W'(i), 1'b1);
      chk("t4_full", 32'(pending_count), 32'd2);
    end
    tick(3);
    e_ready = 1'b0;
    chk("t4_drained", 32'(idle), 32'd1);

    // stall timeout is sticky while the queue keeps working
    beat(3'd4, 2'd1, 1'b1);
    tick(TIMEOUT - 2);
    chk("t5_err_early", 32'(timeout_err), 32'd0);
    tick(3);
    chk("t5_err_set", 32'(timeout_err), 32'd1);
    e_ready = 1'b1;
    tick(2);
    e_ready = 1'b0;
    chk("t5_err_sticky", 32'(timeout_err), 32'd1);
    chk("t5_idle", 32'(idle), 32'd1);

    // reset wins over a same-cycle push and pop
    beat(3'd4, 2'd1, 1'b1);
    beat(3'd4, 2'd2, 1'b1);
    chk("t6_pending", 32'(pending_count), 32'd2);
    reset = 1'b1; e_ready = 1'b1;
    beat(3'd4, 2'd3, 1'b1);
    reset = 1'b0; e_ready = 1'b0;
    chk("t6_pending_rst", 32'(pending_count), 32'd0);
    chk("t6_e_valid_rst", 32'(e_valid), 32'd0);
    chk("t6_idle_rst", 32'(idle), 32'd1);
    chk("t6_err_rst", 32'(timeout_err), 32'd0);
    tick(2);
    chk("t6_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
